// File: rtl/hazard_pkg.sv
// Shared hazard-control definitions: FSM encodings and the memory-read "none" code
// used by decode, ID/EX and the hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MEMWAIT  = 2'd2
  } hz_state_t;

  localparam logic [1:0] MEM_R_NONE = 2'b11;

endpackage : hazard_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [W-1:0] cnt_r;

  // Count register: clear has priority, increment stops at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (clear) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule : sat_counter

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, EX redirects and memory-busy holds
// for the five-stage core. Control outputs are Mealy on state and current inputs.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYC   = 2,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic [1:0]       ex_mem_r,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_err
);

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int BW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYC - 1);
  localparam logic [FW-1:0] FL_ONE     = FW'(1);
  localparam logic [BW-1:0] BUSY_LAST  = BW'(MEM_TIMEOUT - 1);

  hz_state_t     state_r, state_nxt_s;
  logic [FW-1:0] flush_left_r, flush_left_nxt_s;
  logic [BW-1:0] busy_cnt_s;
  logic          mem_err_r;
  logic          lu_s;
  logic          pc_we_s, ifid_we_s, ifid_flush_s, idex_flush_s, pipe_hold_s;

  assign lu_s = (ex_mem_r != MEM_R_NONE) && (ex_rd != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  // Next-state and control decode; hold beats redirect beats load-use.
  always_comb begin
    state_nxt_s      = state_r;
    flush_left_nxt_s = flush_left_r;
    pc_we_s          = 1'b1;
    ifid_we_s        = 1'b1;
    ifid_flush_s     = 1'b0;
    idex_flush_s     = 1'b0;
    pipe_hold_s      = 1'b0;
    if (mem_busy) begin
      pipe_hold_s = 1'b1;
      pc_we_s     = 1'b0;
      ifid_we_s   = 1'b0;
      if (state_r == REDIRECT) begin
        state_nxt_s = REDIRECT;
      end else begin
        state_nxt_s = MEMWAIT;
      end
    end else if (ex_redirect) begin
      ifid_flush_s     = 1'b1;
      idex_flush_s     = 1'b1;
      flush_left_nxt_s = FLUSH_LOAD;
      if (FLUSH_CYC > 1) begin
        state_nxt_s = REDIRECT;
      end else begin
        state_nxt_s = RUN;
      end
    end else begin
      case (state_r)
        REDIRECT: begin
          // ID holds a bubble here, so a load-use match is meaningless.
          ifid_flush_s = 1'b1;
          if (flush_left_r <= FL_ONE) begin
            flush_left_nxt_s = {FW{1'b0}};
            state_nxt_s      = RUN;
          end else begin
            flush_left_nxt_s = flush_left_r - FL_ONE;
            state_nxt_s      = REDIRECT;
          end
        end
        RUN, MEMWAIT: begin
          if (lu_s) begin
            pc_we_s      = 1'b0;
            ifid_we_s    = 1'b0;
            idex_flush_s = 1'b1;
          end else begin
            pc_we_s      = 1'b1;
          end
          state_nxt_s = RUN;
        end
        default: begin
          state_nxt_s = RUN;
        end
      endcase
    end
  end

  // FSM, flush countdown and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= RUN;
      flush_left_r <= {FW{1'b0}};
      mem_err_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      flush_left_r <= flush_left_nxt_s;
      if (mem_busy && (busy_cnt_s >= BUSY_LAST)) begin
        mem_err_r <= 1'b1;
      end else begin
        mem_err_r <= mem_err_r;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~pc_we_s),
    .clear (1'b0),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(BW)) u_busy_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mem_busy),
    .clear (~mem_busy),
    .cnt   (busy_cnt_s)
  );

  // While reset is held the front end is frozen and both pipeline latches bubble.
  assign pc_we      = rst ? 1'b0 : pc_we_s;
  assign ifid_we    = rst ? 1'b0 : ifid_we_s;
  assign ifid_flush = rst ? 1'b1 : ifid_flush_s;
  assign idex_flush = rst ? 1'b1 : idex_flush_s;
  assign pipe_hold  = rst ? 1'b0 : pipe_hold_s;
  assign state      = state_r;
  assign mem_err    = mem_err_r;

endmodule : hazard_ctrl
